// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: opcodes, flag bit positions, FSM states.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;

  // bit positions inside rsp_zcv
  localparam int Z = 2;
  localparam int C = 1;
  localparam int V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT) || (op == OP_NOR);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; last_grant only moves when the grant is actually taken.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic upd,
  output logic gnt_id,
  output logic gnt_any
);

  logic last_grant;

  // on contention the side that did not win last time gets it
  assign gnt_id  = (req0 && req1) ? ~last_grant : req1;
  assign gnt_any = req0 | req1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (upd) begin
      last_grant <= gnt_id;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters; one op in flight, tagged response with backpressure.
// Build option ALU_SHARE_OPCHK_EN: reject unsupported opcodes with rsp_err instead of driving the ALU.
//
// state | meaning
// IDLE  | arbitrate, accept winner, load ALU inputs
// WAIT  | count down ALU latency, then capture result/flags
// RESP  | hold response until rsp_ready
module alu_share_ctrl #(
  parameter int ALU_LATENCY = 1,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_src1,
  input  logic [DW-1:0] req0_src2,
  input  logic [3:0]    req0_op,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_src1,
  input  logic [DW-1:0] req1_src2,
  input  logic [3:0]    req1_op,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_result,
  output logic [2:0]    rsp_zcv,
  output logic          rsp_err,
  output logic [DW-1:0] alu_src1,
  output logic [DW-1:0] alu_src2,
  output logic [3:0]    alu_ctrl,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_zero,
  input  logic          alu_cout,
  input  logic          alu_overflow
);
  import alu_pkg::*;

  localparam logic [2:0] CNT_INIT = 3'(ALU_LATENCY);

  state_e        state;
  logic [2:0]    cnt;
  logic          gnt_id;
  logic          gnt_any;
  logic          accept;
  logic          capture;
  logic          win_ok;
  logic          op_bad_q;
  logic [DW-1:0] win_src1;
  logic [DW-1:0] win_src2;
  logic [3:0]    win_op;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0_valid),
    .req1    (req1_valid),
    .upd     (accept),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  assign accept     = (state == ST_IDLE) && gnt_any;
  assign capture    = (state == ST_WAIT) && (cnt == 3'd0);
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept && gnt_id;

  assign win_src1 = gnt_id ? req1_src1 : req0_src1;
  assign win_src2 = gnt_id ? req1_src2 : req0_src2;
  assign win_op   = gnt_id ? req1_op   : req0_op;

`ifdef ALU_SHARE_OPCHK_EN
  assign win_ok = op_legal(win_op);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_bad_q <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept) op_bad_q <= !win_ok;
      if (capture) rsp_err <= op_bad_q;
    end
  end
`else
  assign win_ok   = 1'b1;
  assign op_bad_q = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 3'd0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zcv    <= 3'b000;
      alu_src1   <= '0;
      alu_src2   <= '0;
      alu_ctrl   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rsp_id <= gnt_id;
            state  <= ST_WAIT;
            // a rejected op skips the ALU and responds on the next edge
            if (win_ok) begin
              alu_src1 <= win_src1;
              alu_src2 <= win_src2;
              alu_ctrl <= win_op;
              cnt      <= CNT_INIT;
            end else begin
              cnt <= 3'd0;
            end
          end
        end
        ST_WAIT: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            rsp_valid  <= 1'b1;
            rsp_result <= op_bad_q ? '0 : alu_result;
            rsp_zcv[Z] <= !op_bad_q && alu_zero;
            rsp_zcv[C] <= !op_bad_q && alu_cout;
            rsp_zcv[V] <= !op_bad_q && alu_overflow;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a one-stage reference ALU on the alu_* side.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [3:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_zcv;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero = 1'b0, alu_cout = 1'b0, alu_overflow = 1'b0;

  int errs = 0;
  int checks = 0;
  int lat, n, cyc, last_cyc;

  always #5 clk = ~clk;

  alu_share_ctrl #(.ALU_LATENCY(1), .DW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_src1    (req0_src1),
    .req0_src2    (req0_src2),
    .req0_op      (req0_op),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_src1    (req1_src1),
    .req1_src2    (req1_src2),
    .req1_op      (req1_op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_zcv      (rsp_zcv),
    .rsp_err      (rsp_err),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_cout     (alu_cout),
    .alu_overflow (alu_overflow)
  );

  // reference ALU, output registered once to match ALU_LATENCY = 1
  logic [31:0] m_res;
  logic [32:0] m_sum;
  logic        m_c, m_v;

  always_comb begin
    m_res = 32'd0;
    m_sum = 33'd0;
    m_c   = 1'b0;
    m_v   = 1'b0;
    case (alu_ctrl)
      4'd0: m_res = alu_src1 & alu_src2;
      4'd1: m_res = alu_src1 | alu_src2;
      4'd2: begin
        m_sum = {1'b0, alu_src1} + {1'b0, alu_src2};
        m_res = m_sum[31:0];
        m_c   = m_sum[32];
        m_v   = (alu_src1[31] == alu_src2[31]) && (m_sum[31] != alu_src1[31]);
      end
      4'd6: begin
        m_sum = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
        m_res = m_sum[31:0];
        m_c   = m_sum[32];
        m_v   = (alu_src1[31] != alu_src2[31]) && (m_sum[31] != alu_src1[31]);
      end
      4'd7:  m_res = {31'd0, ($signed(alu_src1) < $signed(alu_src2))};
      4'd12: m_res = ~(alu_src1 | alu_src2);
      default: m_res = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    alu_result   <= m_res;
    alu_zero     <= (m_res == 32'd0);
    alu_cout     <= m_c;
    alu_overflow <= m_v;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one op on requester rid, wait for acceptance, then for rsp_valid
  task automatic issue(input logic rid, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, output int l);
    if (rid) begin
      req1_valid = 1'b1; req1_src1 = a; req1_src2 = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_src1 = a; req0_src2 = b; req0_op = op;
    end
    #1;
    chk("ready_winner", rid ? req1_ready : req0_ready, 32'd1);
    chk("ready_loser", rid ? req0_ready : req1_ready, 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    l = 0;
    while (!rsp_valid && l < 20) begin
      tick();
      l++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    tick();
    chk("rsp_cleared", rsp_valid, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_src1 = '0; req0_src2 = '0; req0_op = '0;
    req1_valid = 1'b0; req1_src1 = '0; req1_src2 = '0; req1_op = '0;
    repeat (2) tick();

    chk("rst_rsp_valid", rsp_valid, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_zcv", rsp_zcv, 32'd0);
    chk("rst_rsp_id", rsp_id, 32'd0);
    chk("rst_rsp_err", rsp_err, 32'd0);
    chk("rst_alu_src1", alu_src1, 32'd0);
    chk("rst_alu_ctrl", alu_ctrl, 32'd0);
    chk("rst_ready", {req1_ready, req0_ready}, 32'd0);
    rst_n = 1'b1;
    tick();

    // ADD overflow on requester 0
    issue(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 4'd2, lat);
    chk("add_lat", lat, 32'd2);
    chk("add_id", rsp_id, 32'd0);
    chk("add_res", rsp_result, 32'h8000_0000);
    chk("add_zcv", rsp_zcv, 32'b001);
    drain();

    // SUB to zero on requester 1
    issue(1'b1, 32'd5, 32'd5, 4'd6, lat);
    chk("sub_lat", lat, 32'd2);
    chk("sub_id", rsp_id, 32'd1);
    chk("sub_res", rsp_result, 32'h0000_0000);
    chk("sub_zcv", rsp_zcv, 32'b110);
    drain();

    // both requesters busy: strict alternation at one op per 4 clocks
    req0_valid = 1'b1; req0_src1 = 32'hF0F0_F0F0; req0_src2 = 32'hFF00_FF00; req0_op = 4'd0;
    req1_valid = 1'b1; req1_src1 = 32'hF0F0_F0F0; req1_src2 = 32'hFF00_FF00; req1_op = 4'd1;
    n = 0; cyc = 0; last_cyc = 0;
    while (n < 8 && cyc < 200) begin
      tick();
      cyc++;
      if (rsp_valid) begin
        chk("alt_id", rsp_id, n % 2);
        chk("alt_res", rsp_result, (n % 2 == 1) ? 32'hFFF0_FFF0 : 32'hF000_F000);
        if (n > 0) chk("alt_gap", cyc - last_cyc, 32'd4);
        last_cyc = cyc;
        n++;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("alt_count", n, 32'd8);
    drain();

    // SLT with consumer stalled for 5 clocks
    rsp_ready = 1'b0;
    issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd7, lat);
    chk("slt_lat", lat, 32'd2);
    chk("slt_zcv", rsp_zcv, 32'b000);
    req0_valid = 1'b1; req0_src1 = 32'd3; req0_src2 = 32'd4; req0_op = 4'd2;
    req1_valid = 1'b1; req1_src1 = 32'd3; req1_src2 = 32'd4; req1_op = 4'd1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_valid", rsp_valid, 32'd1);
      chk("stall_res", rsp_result, 32'h0000_0001);
      chk("stall_ready", {req1_ready, req0_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("stall_release", rsp_valid, 32'd0);
    chk("stall_next_grant", {req1_ready, req0_ready}, 32'b10);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // opcode 3 outside the supported set
    issue(1'b0, 32'd9, 32'd9, 4'd3, lat);
    chk("op3_id", rsp_id, 32'd0);
`ifdef ALU_SHARE_OPCHK_EN
    chk("op3_lat", lat, 32'd1);
    chk("op3_err", rsp_err, 32'd1);
    chk("op3_res", rsp_result, 32'd0);
    chk("op3_zcv", rsp_zcv, 32'd0);
    chk("op3_alu_ctrl", alu_ctrl, 32'd7);
    chk("op3_alu_src1", alu_src1, 32'hFFFF_FFFF);
`else
    chk("op3_lat", lat, 32'd2);
    chk("op3_err", rsp_err, 32'd0);
    chk("op3_alu_ctrl", alu_ctrl, 32'd3);
    chk("op3_alu_src1", alu_src1, 32'd9);
`endif
    drain();

    // reset while waiting on the ALU
    req0_valid = 1'b1; req0_src1 = 32'd1; req0_src2 = 32'd2; req0_op = 4'd2;
    #1;
    chk("mid_accept", req0_ready, 32'd1);
    tick();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("mid_no_rsp", rsp_valid, 32'd0);
      tick();
    end
    chk("mid_alu_src1", alu_src1, 32'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("mid_grant", {req1_ready, req0_ready}, 32'b01);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
